// File: rtl/m68k_bus_monitor.sv
// 68010 bus-cycle monitor: synchronises the bus strobes, captures one record per
// acknowledged cycle into a valid/ready FIFO. Watchdog built with M68K_BUS_WATCHDOG_EN.
module m68k_bus_monitor #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk40,
  input  logic        reset,
  input  logic        P_AS_n,
  input  logic        P_UDS_n,
  input  logic        P_LDS_n,
  input  logic        P_RW_n,
  input  logic        P_DTACK_n,
  input  logic        P_BERR_n,
  input  logic [2:0]  P_FC,
  input  logic [23:1] P_A,
  input  logic [15:0] P_D,
  output logic        berr_drive,
  output logic        rec_valid,
  output logic [45:0] rec_data,
  input  logic        rec_ready,
  output logic [7:0]  overflow_cnt
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    CAPTURE  = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  sync1_r;
  logic [4:0]  sync2_r;
  logic        as_s;
  logic        uds_s;
  logic        lds_s;
  logic        dtack_s;
  logic        berr_s;
  logic        err_r;
  logic        wd_fire_s;
  logic [45:0] rec_s;
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] count_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;
  logic        accept_s;
  logic [45:0] mem_r [FIFO_DEPTH];

  assign {as_s, uds_s, lds_s, dtack_s, berr_s} = sync2_r;

  // Two-flop synchronisers for the asynchronous strobes, idle-high out of reset.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'b11111;
      sync2_r <= 5'b11111;
    end else begin
      sync1_r <= {P_AS_n, P_UDS_n, P_LDS_n, P_DTACK_n, P_BERR_n};
      sync2_r <= sync1_r;
    end
  end

`ifdef M68K_BUS_WATCHDOG_EN
  logic [15:0] wd_cnt_r;

  // Fires on the clock the count reaches TIMEOUT_CYCLES-1, only while no ack or abort is pending.
  assign wd_fire_s = (state_r == ACTIVE) && dtack_s && berr_s && !as_s &&
                     (wd_cnt_r == 16'(TIMEOUT_CYCLES - 2));

  // Watchdog counter: cleared outside ACTIVE, counts each clock in ACTIVE.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ACTIVE) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= 16'd0;
    end
  end

  // Bus-error drive: set on timeout, released together with the return to IDLE.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      berr_drive <= 1'b0;
    end else if (wd_fire_s) begin
      berr_drive <= 1'b1;
    end else if ((state_r == WAIT_END) && as_s) begin
      berr_drive <= 1'b0;
    end
  end
`else
  assign wd_fire_s  = 1'b0;
  assign berr_drive = 1'b0;
`endif

  // Bus-cycle tracker; an acknowledge has priority over a simultaneous AS release.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!as_s) state_r <= ACTIVE;
        end
        ACTIVE: begin
          if (!dtack_s || !berr_s) begin
            state_r <= CAPTURE;
            err_r   <= !berr_s;
          end else if (as_s) begin
            state_r <= IDLE;
          end else if (wd_fire_s) begin
            state_r <= CAPTURE;
            err_r   <= 1'b1;
          end
        end
        CAPTURE: begin
          state_r <= WAIT_END;
        end
        WAIT_END: begin
          if (as_s) state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rec_s    = {P_RW_n, P_FC, !uds_s, !lds_s, err_r, P_A, P_D};
  assign count_s  = wr_ptr_r - rd_ptr_r;
  assign full_s   = (count_s == PTR_DEPTH);
  assign push_s   = (state_r == CAPTURE);
  assign pop_s    = rec_valid && rec_ready;
  assign accept_s = push_s && (!full_s || pop_s);

  // FIFO pointers carry one extra bit so a full FIFO is distinct from an empty one.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)    rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Record storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk40) begin
    if (accept_s) mem_r[wr_ptr_r[AW-1:0]] <= rec_s;
  end

  // Dropped-record counter, saturating.
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      overflow_cnt <= 8'd0;
    end else if (push_s && full_s && !pop_s && (overflow_cnt != 8'hFF)) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Head-of-FIFO presentation; data forced to zero while empty.
  always_comb begin
    rec_valid = (count_s != {(AW+1){1'b0}});
    if (rec_valid) begin
      rec_data = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      rec_data = 46'd0;
    end
  end

endmodule

// File: tb/tb_m68k_bus_monitor.sv
// Randomised self-checking bench for m68k_bus_monitor against a queue-based record model.
`timescale 1ns/1ps
module tb_m68k_bus_monitor;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic        clk40 = 1'b0;
  logic        reset = 1'b1;
  logic        P_AS_n = 1'b1, P_UDS_n = 1'b1, P_LDS_n = 1'b1, P_RW_n = 1'b1;
  logic        P_DTACK_n = 1'b1, P_BERR_n = 1'b1;
  logic [2:0]  P_FC = 3'd0;
  logic [23:1] P_A = 23'd0;
  logic [15:0] P_D = 16'd0;
  logic        berr_drive, rec_valid, rec_ready = 1'b0;
  logic [45:0] rec_data;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;
  int ovf_model = 0;
  logic [45:0] exp_q[$];
  logic [45:0] obs_q[$];

  m68k_bus_monitor #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk40(clk40), .reset(reset), .P_AS_n(P_AS_n), .P_UDS_n(P_UDS_n), .P_LDS_n(P_LDS_n),
    .P_RW_n(P_RW_n), .P_DTACK_n(P_DTACK_n), .P_BERR_n(P_BERR_n), .P_FC(P_FC), .P_A(P_A),
    .P_D(P_D), .berr_drive(berr_drive), .rec_valid(rec_valid), .rec_data(rec_data),
    .rec_ready(rec_ready), .overflow_cnt(overflow_cnt)
  );

  always #5 clk40 = ~clk40;

  // Records handed over on a valid/ready clock, sampled mid-cycle.
  always @(negedge clk40) begin
    if (!reset && rec_valid && rec_ready) obs_q.push_back(rec_data);
  end

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  function automatic logic [45:0] mk_rec(input logic rw, input logic [2:0] fc, input logic uds,
                                         input logic lds, input logic err, input logic [22:0] a,
                                         input logic [15:0] d);
    return {rw, fc, uds, lds, err, a, d};
  endfunction

  // Model: a record is stored if the FIFO (accepted minus delivered) has room, else dropped.
  task automatic model_capture(input logic [45:0] rec);
    if (exp_q.size() - obs_q.size() < DEPTH) exp_q.push_back(rec);
    else if (ovf_model < 255) ovf_model++;
  endtask

  task automatic release_bus();
    P_AS_n = 1'b1; P_UDS_n = 1'b1; P_LDS_n = 1'b1; P_DTACK_n = 1'b1; P_BERR_n = 1'b1;
  endtask

  // One complete bus cycle; the record lands in the FIFO on the 4th clock after the ack.
  task automatic do_cycle(input logic rw, input logic [2:0] fc, input logic [22:0] a,
                          input logic [15:0] d, input logic uds, input logic lds, input int dly,
                          input logic use_berr, input logic pulse);
    P_RW_n = rw; P_FC = fc; P_A = a; P_D = d;
    P_AS_n = 1'b0; P_UDS_n = !uds; P_LDS_n = !lds;
    repeat (dly) tick();
    if (use_berr) P_BERR_n = 1'b0;
    else P_DTACK_n = 1'b0;
    repeat (3) tick();
    if (pulse) rec_ready = 1'b1;
    tick();
    if (pulse) rec_ready = 1'b0;
    model_capture(mk_rec(rw, fc, uds, lds, use_berr, a, d));
    repeat (2) tick();
    release_bus();
    repeat (5) tick();
  endtask

  task automatic drain();
    rec_ready = 1'b1;
    for (int i = 0; i < 200 && (rec_valid || obs_q.size() < exp_q.size()); i++) tick();
    rec_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    release_bus();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (rec_valid !== 1'b0 || rec_data !== 46'd0) begin
      errors++; $display("FAIL reset_out got valid=%b data=%h want 0/0", rec_valid, rec_data);
    end
    checks++;
    if (overflow_cnt !== 8'd0 || berr_drive !== 1'b0) begin
      errors++; $display("FAIL reset_cnt got ovf=%0d berr=%b want 0/0", overflow_cnt, berr_drive);
    end
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid got %b want 0", rec_valid);
    end
  endtask

  task automatic test_read_basic();
    logic [45:0] want;
    want = mk_rec(1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 23'h778000, 16'h1234);
    rec_ready = 1'b1;
    do_cycle(1'b1, 3'd5, 23'h778000, 16'h1234, 1'b1, 1'b1, 6, 1'b0, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL basic_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== want) begin
        errors++; $display("FAIL basic_rec got %h want %h", obs_q[0], want);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      rec_ready = 1'($urandom_range(0, 1));
      do_cycle(1'($urandom), 3'($urandom), 23'($urandom), 16'($urandom), 1'($urandom),
               1'($urandom), $urandom_range(3, 10), ($urandom_range(0, 7) == 0), 1'b0);
    end
    checks++;
    if (overflow_cnt !== 8'(ovf_model)) begin
      errors++; $display("FAIL rand_ovf got %0d want %0d", overflow_cnt, ovf_model);
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_rec[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Ten word writes with no consumer, then a capture that coincides with a single pop.
  task automatic test_overflow_and_full_pop();
    logic [45:0] head;
    int base_ovf;
    rec_ready = 1'b0;
    base_ovf = ovf_model;
    for (int n = 0; n < 10; n++)
      do_cycle(1'b0, 3'd1, 23'($urandom), 16'($urandom), 1'b1, 1'b1, 4, 1'b0, 1'b0);
    checks++;
    if (overflow_cnt !== 8'(base_ovf + 2) || overflow_cnt !== 8'(ovf_model)) begin
      errors++; $display("FAIL ovf_count got %0d want %0d", overflow_cnt, base_ovf + 2);
    end
    head = rec_data;
    repeat (3) tick();
    checks++;
    if (rec_valid !== 1'b1 || rec_data !== exp_q[0] || head !== exp_q[0]) begin
      errors++; $display("FAIL hold_head got %h/%h want %h", head, rec_data, exp_q[0]);
    end
    do_cycle(1'b1, 3'd6, 23'h123456, 16'hBEEF, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    checks++;
    if (overflow_cnt !== 8'(base_ovf + 2)) begin
      errors++; $display("FAIL full_pop_ovf got %0d want %0d", overflow_cnt, base_ovf + 2);
    end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 9) begin
      errors++; $display("FAIL full_pop_seen got %0d/%0d want 1/9", obs_q.size(), exp_q.size());
    end
    drain();
    checks++;
    if (obs_q.size() != 9) begin
      errors++; $display("FAIL full_pop_drain got %0d want 9", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_rec[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    rec_ready = 1'b0;
    P_RW_n = 1'b1; P_AS_n = 1'b0; P_UDS_n = 1'b0; P_LDS_n = 1'b0;
    repeat (4) tick();
    release_bus();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (berr_drive !== 1'b0 || rec_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort got %0d cycles with berr/valid set want 0", bad);
    end
  endtask

  task automatic test_watchdog();
    logic [45:0] want;
    int early;
    early = 0;
    rec_ready = 1'b0;
    want = mk_rec(1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 23'h0ABCDE, 16'h5A5A);
    P_RW_n = 1'b1; P_FC = 3'd2; P_A = 23'h0ABCDE; P_D = 16'h5A5A;
    P_AS_n = 1'b0; P_UDS_n = 1'b0; P_LDS_n = 1'b1;
`ifdef M68K_BUS_WATCHDOG_EN
    for (int i = 0; i < 17; i++) begin
      tick();
      if (berr_drive !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL wd_early got %0d early clocks want 0", early);
    end
    tick();
    checks++;
    if (berr_drive !== 1'b1) begin
      errors++; $display("FAIL wd_fire got %b want 1", berr_drive);
    end
    tick();
    model_capture(want);
    repeat (3) tick();
    release_bus();
    repeat (2) tick();
    checks++;
    if (berr_drive !== 1'b1) begin
      errors++; $display("FAIL wd_hold got %b want 1", berr_drive);
    end
    tick();
    checks++;
    if (berr_drive !== 1'b0) begin
      errors++; $display("FAIL wd_release got %b want 0", berr_drive);
    end
    repeat (3) tick();
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (berr_drive !== 1'b0 || rec_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL nowd_wait got %0d bad clocks want 0", early);
    end
    want[39] = 1'b0;
    P_DTACK_n = 1'b0;
    repeat (4) tick();
    model_capture(want);
    repeat (2) tick();
    release_bus();
    repeat (5) tick();
`endif
    drain();
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL wd_count got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== want) begin
        errors++; $display("FAIL wd_rec got %h want %h", obs_q[0], want);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Reset mid-cycle with three stored records and a nonzero drop count.
  task automatic test_reset_midcycle();
    logic [45:0] want;
    rec_ready = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++)
      do_cycle(1'b0, 3'd3, 23'($urandom), 16'($urandom), 1'b1, 1'b1, 3, 1'b0, 1'b0);
    drain();
    exp_q.delete(); obs_q.delete();
    for (int n = 0; n < 3; n++)
      do_cycle(1'b1, 3'd1, 23'($urandom), 16'($urandom), 1'b1, 1'b1, 3, 1'b0, 1'b0);
    P_AS_n = 1'b0; P_UDS_n = 1'b0; P_LDS_n = 1'b0;
    repeat (4) tick();
    checks++;
    if (overflow_cnt === 8'd0 || rec_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got ovf=%0d valid=%b want >0/1", overflow_cnt, rec_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (rec_valid !== 1'b0 || overflow_cnt !== 8'd0 || rec_data !== 46'd0) begin
      errors++; $display("FAIL mid_reset got valid=%b ovf=%0d want 0/0", rec_valid, overflow_cnt);
    end
    exp_q.delete(); obs_q.delete(); ovf_model = 0;
    repeat (2) tick();
    reset = 1'b0;
    want = mk_rec(1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 23'h7FFFFF, 16'hC0DE);
    do_cycle(1'b1, 3'd7, 23'h7FFFFF, 16'hC0DE, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    checks++;
    if (rec_valid !== 1'b1 || rec_data !== want) begin
      errors++; $display("FAIL post_reset got %b/%h want 1/%h", rec_valid, rec_data, want);
    end
    drain();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL post_reset_count got %0d want 1", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_random();
    test_overflow_and_full_pop();
    test_abort();
    test_watchdog();
    test_reset_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_monitor.md
M68K_BUS_MONITOR -- requirements
Module: m68k_bus_monitor

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: record FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: clk40 cycles from AS assertion to watchdog bus error; range 16..65535.
REQ-003 clk40  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 P_AS_n, P_UDS_n, P_LDS_n, P_RW_n, P_DTACK_n, P_BERR_n  in  1 each  68010 bus strobes, asynchronous to clk40.
REQ-006 P_FC  in  3  function code; P_A  in  23  address A23..A1; P_D  in  16  data bus.
REQ-007 berr_drive  out  1  high = pull P_BERR_n low; the parent supplies the open-drain driver.
REQ-008 rec_valid  out  1; rec_data  out  46; rec_ready  in  1: valid/ready record output.
REQ-009 overflow_cnt  out  8  count of records dropped on a full FIFO, saturating.

Function
REQ-010 AS_n, UDS_n, LDS_n, DTACK_n and BERR_n SHALL pass through two-flop synchronisers; all decisions use the synchronised values.
REQ-011 FSM states: IDLE, ACTIVE, CAPTURE, WAIT_END.
REQ-012 IDLE -> ACTIVE when synced AS is low.
REQ-013 ACTIVE -> CAPTURE when synced DTACK or synced BERR is low, or when the watchdog fires.
REQ-014 CAPTURE lasts exactly one clock and then moves to WAIT_END.
REQ-015 WAIT_END -> IDLE when synced AS is high.
REQ-016 ACTIVE -> IDLE with no record when AS rises before any acknowledge; this is an aborted cycle.
REQ-017 In CAPTURE the block SHALL sample P_RW_n, P_FC, P_A and P_D directly, plus synced UDS/LDS. Inputs are stable two clocks after DTACK falls.
REQ-018 rec_data layout: [45] rw (1 = read), [44:42] fc, [41] uds active, [40] lds active, [39] err, [38:16] A23..A1, [15:0] data.
- err = 1 if BERR (external or watchdog) terminated the cycle.
REQ-019 The record SHALL be written to the FIFO in CAPTURE. If the FIFO is full, the record is dropped and overflow_cnt increments, saturating at 255.
REQ-020 rec_valid = FIFO not empty, and rec_data shows the head entry.
- rec_valid is high no later than 1 clock after the write.
- The head is popped on a clock where rec_valid and rec_ready are both high.
REQ-021 A push and a pop in the same clock on a full FIFO SHALL both succeed, with no drop.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH, with a separate full/empty distinction so that all FIFO_DEPTH entries are usable.
REQ-023 rec_data and rec_valid SHALL be stable while rec_valid is high and rec_ready is low.

Reset
REQ-024 While reset is high:
- FSM = IDLE; FIFO empty; rec_valid = 0; rec_data = 0.
- overflow_cnt = 0; berr_drive = 0; synchronisers = 1; watchdog counter = 0.
REQ-025 Reset asserted mid-cycle SHALL discard the in-progress cycle and all FIFO contents.
REQ-026 After reset deasserts, a cycle whose AS is already low SHALL be tracked only after it has passed through the synchroniser; it is then recorded normally.

Configuration
REQ-027 Macro M68K_BUS_WATCHDOG_EN, when defined:
- A 16-bit counter clears in IDLE and increments each clock in ACTIVE.
- On reaching TIMEOUT_CYCLES-1 it fires: berr_drive = 1 and the cycle is recorded with err = 1.
- berr_drive is held high until synced AS goes high, then drops in the same clock that the FSM enters IDLE.
REQ-028 Without M68K_BUS_WATCHDOG_EN:
- No counter logic is built and berr_drive is tied 0.
- ACTIVE waits indefinitely for DTACK or BERR.

Verification
REQ-029 Read, FC=5, A=0xEF0000 (P_A=0x778000), D=0x1234, UDS=LDS=0, DTACK after 6 clocks, rec_ready=1 -> one record: rw=1, fc=5, uds=lds=1, err=0, A field 0x778000, data 0x1234.
REQ-030 rec_ready=0, 10 word-write cycles, FIFO_DEPTH=8 -> first 8 records held; overflow_cnt=2; after ready rises, records come out in order.
REQ-031 FIFO full plus a new capture in the same clock that rec_ready=1 -> no drop, overflow_cnt unchanged, count stays 8.
REQ-032 Watchdog built, TIMEOUT_CYCLES=16, AS low with no DTACK -> berr_drive rises 16 clocks after synced AS; record has err=1; berr_drive falls when AS is released.
REQ-033 AS pulse of 4 clocks with no acknowledge -> no record, berr_drive stays 0.
REQ-034 reset pulsed in ACTIVE with 3 FIFO entries -> rec_valid=0 and overflow_cnt=0 immediately; the next full cycle is recorded normally.
